knn_seq_ctrl: RTL and testbench

KNN_SEQ_CTRL -- requirements
Module: knn_seq_ctrl

---
 rtl/knn_seq_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_knn_seq_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/knn_seq_ctrl.sv
// rtl/knn_seq_ctrl.sv - job sequencer feeding a KNN core from a word stream and draining its results
module knn_seq_ctrl #(
  parameter int dataWidth          = 32,
  parameter int numberOfDimensions = 5,
  parameter int drainCycles        = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_start,
  input  logic                 cmd_abort,
  input  logic [31:0]          cmd_k,
  input  logic [31:0]          cmd_numVectors,
  input  logic                 s_valid,
  input  logic [dataWidth-1:0] s_data,
  output logic                 s_ready,
  output logic                 knn_start,
  output logic                 knn_wr_en,
  output logic                 knn_rd_en,
  output logic                 knn_done,
  output logic [31:0]          knn_k,
  output logic [dataWidth-1:0] knn_dataValueIn,
  input  logic [31:0]          knn_dataNameOut,
  input  logic [dataWidth-1:0] knn_dataValueOut,
  output logic                 m_valid,
  output logic [31:0]          m_name,
  output logic [dataWidth-1:0] m_value,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 job_done,
  output logic                 err
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_LOAD, S_FLUSH, S_READ, S_FIN} state_t;
  // READ sub-phase: rd_en pulse cycle, core-data capture cycle, result handshake wait
  typedef enum logic [1:0] {RP_PULSE, RP_CAP, RP_WAIT} rphase_t;

  localparam logic [31:0] LP_DIM_LAST = 32'(numberOfDimensions - 1);
  localparam logic [31:0] LP_DRAIN    = 32'(drainCycles);

  state_t               r_state, w_state_nxt;
  rphase_t              r_rphase, w_rphase_nxt;
  logic [31:0]          r_dim, w_dim_nxt;
  logic [31:0]          r_vec, w_vec_nxt;
  logic [31:0]          r_drain, w_drain_nxt;
  logic [31:0]          r_res, w_res_nxt;
  logic [31:0]          r_n, w_n_nxt;
  logic [31:0]          r_r, w_r_nxt;
  logic [31:0]          r_knn_k, w_knn_k_nxt;
  logic [dataWidth-1:0] r_data_in, w_data_in_nxt;
  logic [31:0]          r_m_name, w_m_name_nxt;
  logic [dataWidth-1:0] r_m_value, w_m_value_nxt;
  logic                 r_m_valid, w_m_valid_nxt;
  logic                 r_wr_en, w_wr_en_nxt;
  logic                 r_rd_en, w_rd_en_nxt;
  logic                 r_job_done, w_job_done_nxt;
  logic                 r_err, w_err_nxt;
  logic                 r_s_ready, r_knn_start, r_knn_done, r_busy;
  logic                 w_beat;

  assign w_beat = r_s_ready & s_valid;

  // Next-state and next-output computation; level outputs are derived from the next state
  always_comb begin
    w_state_nxt    = r_state;
    w_rphase_nxt   = r_rphase;
    w_dim_nxt      = r_dim;
    w_vec_nxt      = r_vec;
    w_drain_nxt    = r_drain;
    w_res_nxt      = r_res;
    w_n_nxt        = r_n;
    w_r_nxt        = r_r;
    w_knn_k_nxt    = r_knn_k;
    w_data_in_nxt  = r_data_in;
    w_m_name_nxt   = r_m_name;
    w_m_value_nxt  = r_m_value;
    w_m_valid_nxt  = r_m_valid;
    w_wr_en_nxt    = 1'b0;
    w_rd_en_nxt    = 1'b0;
    w_job_done_nxt = 1'b0;
    w_err_nxt      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (cmd_start && !cmd_abort) begin
          if (cmd_k == 32'd0 || cmd_numVectors == 32'd0) begin
            w_err_nxt = 1'b1;
          end else begin
            w_knn_k_nxt = cmd_k;
            w_n_nxt     = cmd_numVectors;
            w_r_nxt     = (cmd_k < cmd_numVectors) ? cmd_k : cmd_numVectors;
            w_dim_nxt   = 32'd0;
            w_vec_nxt   = 32'd0;
            w_drain_nxt = 32'd0;
            w_res_nxt   = 32'd0;
            w_state_nxt = S_ARM;
          end
        end
      end
      S_ARM: w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (w_beat) begin
          w_wr_en_nxt   = 1'b1;
          w_data_in_nxt = s_data;
          if (r_dim == LP_DIM_LAST) begin
            w_dim_nxt = 32'd0;
            // vector 0 is the reference, so the last word belongs to vector N
            if (r_vec == r_n) w_state_nxt = S_FLUSH;
            else              w_vec_nxt   = r_vec + 32'd1;
          end else begin
            w_dim_nxt = r_dim + 32'd1;
          end
        end
      end
      S_FLUSH: begin
        if (r_drain + 32'd1 >= LP_DRAIN) begin
          w_drain_nxt  = 32'd0;
          w_state_nxt  = S_READ;
          w_rd_en_nxt  = 1'b1;
          w_rphase_nxt = RP_PULSE;
        end else begin
          w_drain_nxt = r_drain + 32'd1;
        end
      end
      S_READ: begin
        case (r_rphase)
          RP_PULSE: w_rphase_nxt = RP_CAP;
          RP_CAP: begin
            w_m_name_nxt  = knn_dataNameOut;
            w_m_value_nxt = knn_dataValueOut;
            w_m_valid_nxt = 1'b1;
            w_rphase_nxt  = RP_WAIT;
          end
          default: begin
            if (r_m_valid && m_ready) begin
              w_m_valid_nxt = 1'b0;
              w_res_nxt     = r_res + 32'd1;
              if (r_res + 32'd1 == r_r) begin
                w_state_nxt    = S_FIN;
                w_job_done_nxt = 1'b1;
              end else begin
                w_rd_en_nxt  = 1'b1;
                w_rphase_nxt = RP_PULSE;
              end
            end
          end
        endcase
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
        w_dim_nxt   = 32'd0;
        w_vec_nxt   = 32'd0;
        w_drain_nxt = 32'd0;
        w_res_nxt   = 32'd0;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Abort drops the job on the next edge; latched k and data words are left in place
    if (cmd_abort && r_state != S_IDLE) begin
      w_state_nxt    = S_IDLE;
      w_rphase_nxt   = RP_PULSE;
      w_dim_nxt      = 32'd0;
      w_vec_nxt      = 32'd0;
      w_drain_nxt    = 32'd0;
      w_res_nxt      = 32'd0;
      w_m_valid_nxt  = 1'b0;
      w_wr_en_nxt    = 1'b0;
      w_rd_en_nxt    = 1'b0;
      w_job_done_nxt = 1'b0;
    end
  end

  // State and output registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rphase    <= RP_PULSE;
      r_dim       <= '0;
      r_vec       <= '0;
      r_drain     <= '0;
      r_res       <= '0;
      r_n         <= '0;
      r_r         <= '0;
      r_knn_k     <= '0;
      r_data_in   <= '0;
      r_m_name    <= '0;
      r_m_value   <= '0;
      r_m_valid   <= 1'b0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_job_done  <= 1'b0;
      r_err       <= 1'b0;
      r_s_ready   <= 1'b0;
      r_knn_start <= 1'b0;
      r_knn_done  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rphase    <= w_rphase_nxt;
      r_dim       <= w_dim_nxt;
      r_vec       <= w_vec_nxt;
      r_drain     <= w_drain_nxt;
      r_res       <= w_res_nxt;
      r_n         <= w_n_nxt;
      r_r         <= w_r_nxt;
      r_knn_k     <= w_knn_k_nxt;
      r_data_in   <= w_data_in_nxt;
      r_m_name    <= w_m_name_nxt;
      r_m_value   <= w_m_value_nxt;
      r_m_valid   <= w_m_valid_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_job_done  <= w_job_done_nxt;
      r_err       <= w_err_nxt;
      r_s_ready   <= (w_state_nxt == S_LOAD);
      r_knn_start <= (w_state_nxt != S_IDLE);
      r_knn_done  <= (w_state_nxt == S_FLUSH) || (w_state_nxt == S_READ);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign s_ready         = r_s_ready;
  assign knn_start       = r_knn_start;
  assign knn_wr_en       = r_wr_en;
  assign knn_rd_en       = r_rd_en;
  assign knn_done        = r_knn_done;
  assign knn_k           = r_knn_k;
  assign knn_dataValueIn = r_data_in;
  assign m_valid         = r_m_valid;
  assign m_name          = r_m_name;
  assign m_value         = r_m_value;
  assign busy            = r_busy;
  assign job_done        = r_job_done;
  assign err             = r_err;

endmodule

// File: tb/tb_knn_seq_ctrl.sv
// tb/tb_knn_seq_ctrl.sv - self-checking bench for knn_seq_ctrl
module tb_knn_seq_ctrl;
  localparam int DW = 32;
  localparam int ND = 5;
  localparam int DC = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_start, cmd_abort;
  logic [31:0]   cmd_k, cmd_numVectors;
  logic          s_valid, s_ready;
  logic [DW-1:0] s_data;
  logic          knn_start, knn_wr_en, knn_rd_en, knn_done;
  logic [31:0]   knn_k;
  logic [DW-1:0] knn_dataValueIn;
  logic [31:0]   knn_dataNameOut;
  logic [DW-1:0] knn_dataValueOut;
  logic          m_valid, m_ready;
  logic [31:0]   m_name;
  logic [DW-1:0] m_value;
  logic          busy, job_done, err;

  always #5 clk = ~clk;

  knn_seq_ctrl #(.dataWidth(DW), .numberOfDimensions(ND), .drainCycles(DC)) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .cmd_k(cmd_k), .cmd_numVectors(cmd_numVectors),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .knn_start(knn_start), .knn_wr_en(knn_wr_en), .knn_rd_en(knn_rd_en), .knn_done(knn_done),
    .knn_k(knn_k), .knn_dataValueIn(knn_dataValueIn),
    .knn_dataNameOut(knn_dataNameOut), .knn_dataValueOut(knn_dataValueOut),
    .m_valid(m_valid), .m_name(m_name), .m_value(m_value), .m_ready(m_ready),
    .busy(busy), .job_done(job_done), .err(err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic any_out();
    return |{s_ready, knn_start, knn_wr_en, knn_rd_en, knn_done, knn_k, knn_dataValueIn,
             m_valid, m_name, m_value, busy, job_done, err};
  endfunction

  typedef struct {
    int k; int n; int vmode; int stall; int abort_after;
    int exp_err; int exp_wr; int exp_res; int exp_jd;
  } vec_t;

  // vmode: 0 back-to-back valid, 1 valid every other cycle, 2 random valid and random m_ready
  task automatic run_job(input vec_t v);
    logic [DW-1:0] words[$];
    logic [DW-1:0] exp_wr_q[$];
    logic [31:0]   exp_nm[$];
    logic [DW-1:0] exp_val[$];
    int ref_v[5] = '{1, -2, 2, -2, 3};
    int total, cyc, sent, wr_cnt, wr_bad, err_cnt, jd_cnt, rd_cnt, rd_pre_hs, hs, res_bad;
    int done_pre_rd, first_done, last_acc, busy_cnt, unstable, max_run, run;
    int stall_left, abort_chk, finish_at;
    bit acc_prev, first_rd_seen, aborted, poked, hold_valid, arm_ok, arm_seen;
    logic [31:0]   hold_nm, nm, enm;
    logic [DW-1:0] hold_val, vl, evl, ew;

    total = (v.k == 0 || v.n == 0) ? 0 : (v.n + 1) * ND;
    for (int i = 0; i < total; i++) words.push_back((i < 5) ? DW'(ref_v[i]) : DW'($urandom));
    sent = 0; wr_cnt = 0; wr_bad = 0; err_cnt = 0; jd_cnt = 0; rd_cnt = 0; rd_pre_hs = 0;
    hs = 0; res_bad = 0; done_pre_rd = 0; first_done = -1; last_acc = -1; busy_cnt = 0;
    unstable = 0; max_run = 0; run = 0; stall_left = v.stall; abort_chk = -1;
    finish_at = (total == 0) ? 4 : -1;
    acc_prev = 0; first_rd_seen = 0; aborted = 0; poked = 0; hold_valid = 0;
    arm_ok = 0; arm_seen = 0; hold_nm = '0; hold_val = '0;

    @(negedge clk);
    cmd_k = v.k; cmd_numVectors = v.n; cmd_start = 1'b1;
    for (cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      cmd_start = 1'b0; cmd_abort = 1'b0; cmd_k = v.k;
      if (busy) busy_cnt++;
      if (busy && !arm_seen) begin arm_seen = 1; arm_ok = knn_start && (knn_k == v.k); end
      if (err) err_cnt++;
      if (job_done) jd_cnt++;
      if (knn_wr_en) begin
        wr_cnt++; run++;
        if (run > max_run) max_run = run;
        if (!acc_prev || exp_wr_q.size() == 0) wr_bad++;
        else begin ew = exp_wr_q.pop_front(); if (knn_dataValueIn !== ew) wr_bad++; end
      end else run = 0;
      if (knn_done && first_done < 0) first_done = cyc;
      if (knn_done && !first_rd_seen && !knn_rd_en) done_pre_rd++;
      if (knn_rd_en) begin
        rd_cnt++; first_rd_seen = 1;
        if (hs == 0) rd_pre_hs++;
        nm = $urandom; vl = $urandom;
        knn_dataNameOut = nm; knn_dataValueOut = vl;
        exp_nm.push_back(nm); exp_val.push_back(vl);
      end
      if (hold_valid && (!m_valid || m_name !== hold_nm || m_value !== hold_val)) unstable++;
      m_ready = (m_valid && stall_left > 0) ? 1'b0 : ((v.vmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1);
      if (m_valid && stall_left > 0) stall_left--;
      hold_valid = m_valid && !m_ready; hold_nm = m_name; hold_val = m_value;
      if (m_valid && m_ready) begin
        hs++;
        if (exp_nm.size() == 0) res_bad++;
        else begin
          enm = exp_nm.pop_front(); evl = exp_val.pop_front();
          if (m_name !== enm || m_value !== evl) res_bad++;
        end
      end
      if (cyc == abort_chk) begin
        check("abort_idle", {knn_start, knn_wr_en, knn_rd_en, knn_done, s_ready, busy}, 0);
        check("abort_no_job_done", job_done, 0);
      end
      if (v.abort_after >= 0 && !aborted && sent == v.abort_after) begin
        cmd_abort = 1'b1; aborted = 1; abort_chk = cyc + 1; finish_at = cyc + 4;
      end
      if (!poked && sent == 2 && !cmd_abort) begin
        cmd_start = 1'b1; cmd_k = v.k + 5; poked = 1;
      end
      acc_prev = 0; s_valid = 1'b0;
      if (!cmd_abort && sent < total &&
          (v.vmode == 0 || (v.vmode == 1 && cyc % 2 == 0) || (v.vmode == 2 && $urandom_range(0, 1) == 1))) begin
        s_valid = 1'b1; s_data = words[sent];
        if (s_ready) begin acc_prev = 1; exp_wr_q.push_back(words[sent]); sent++; last_acc = cyc; end
      end
      if (job_done && finish_at < 0) finish_at = cyc + 2;
      if (cyc == finish_at) break;
    end
    s_valid = 1'b0; m_ready = 1'b1;

    check("job_timeout", (cyc >= 3000), 0);
    check("err_pulses", err_cnt, v.exp_err);
    check("job_done_pulses", jd_cnt, v.exp_jd);
    if (v.exp_err != 0) begin
      check("err_busy_cycles", busy_cnt, 0);
    end else begin
      check("arm_start_k", arm_ok, 1);
      check("wr_en_count", wr_cnt, v.exp_wr);
      check("wr_data_order", wr_bad, 0);
      check("rd_en_count", rd_cnt, v.exp_res);
      check("end_busy_ctrl", {busy, knn_start, knn_wr_en, knn_rd_en, knn_done, s_ready, m_valid}, 0);
      if (v.abort_after < 0) begin
        check("done_before_rd", done_pre_rd, DC);
        check("flush_after_last_beat", first_done, last_acc + 1);
        check("result_handshakes", hs, v.exp_res);
        check("result_values", res_bad, 0);
        check("result_stable", unstable, 0);
        check("knn_k_held", knn_k, v.k);
      end
      if (v.vmode == 0 && v.abort_after < 0) check("wr_en_contiguous", max_run, v.exp_wr);
      if (v.stall > 0) check("rd_before_first_hs", rd_pre_hs, 1);
    end
    repeat (2) @(negedge clk);
  endtask

  vec_t tbl[8];
  vec_t rv;

  initial begin
    tbl[0] = '{3, 5, 0, 0, -1, 0, 30, 3, 1};
    tbl[1] = '{3, 5, 1, 0, -1, 0, 30, 3, 1};
    tbl[2] = '{3, 5, 0, 5, -1, 0, 30, 3, 1};
    tbl[3] = '{0, 5, 0, 0, -1, 1, 0, 0, 0};
    tbl[4] = '{3, 0, 0, 0, -1, 1, 0, 0, 0};
    tbl[5] = '{7, 2, 0, 0, -1, 0, 15, 2, 1};
    tbl[6] = '{3, 5, 0, 0, 12, 0, 12, 0, 0};
    tbl[7] = '{3, 5, 0, 0, -1, 0, 30, 3, 1};

    reset = 1'b1; cmd_start = 1'b0; cmd_abort = 1'b0; cmd_k = '0; cmd_numVectors = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b1; knn_dataNameOut = '0; knn_dataValueOut = '0;
    repeat (4) @(negedge clk);
    check("reset_outputs_zero", any_out(), 0);
    check("reset_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_job(tbl[i]);

    // abort and start together in IDLE: no job is taken
    cmd_start = 1'b1; cmd_abort = 1'b1; cmd_k = 3; cmd_numVectors = 5;
    @(negedge clk);
    cmd_start = 1'b0; cmd_abort = 1'b0;
    check("abort_start_idle_busy", busy, 0);
    check("abort_start_idle_err", err, 0);
    repeat (2) @(negedge clk);
    check("abort_start_idle_busy_later", busy, 0);

    // reset in the middle of a job clears everything
    cmd_start = 1'b1; cmd_k = 2; cmd_numVectors = 1;
    @(negedge clk);
    cmd_start = 1'b0; s_valid = 1'b1; s_data = 32'h55;
    repeat (6) @(negedge clk);
    check("midjob_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("midjob_reset_zero", any_out(), 0);
    reset = 1'b0; s_valid = 1'b0;
    @(negedge clk);

    // randomized jobs against the arithmetic job model
    for (int j = 0; j < 8; j++) begin
      rv.k = $urandom_range(1, 8);
      rv.n = $urandom_range(1, 6);
      rv.vmode = 2;
      rv.stall = $urandom_range(0, 3);
      rv.abort_after = -1;
      rv.exp_err = 0;
      rv.exp_wr = (rv.n + 1) * ND;
      rv.exp_res = (rv.k < rv.n) ? rv.k : rv.n;
      rv.exp_jd = 1;
      run_job(rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
